// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA box renderer.
// Holds resolution defaults, colour field slices and default colours.
package vga_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int POS_W     = 11;
  localparam int COLOR_W   = 8;

  // Colour fields for the RRRGGGBB DAC layout
  localparam int RED_MSB   = 7;
  localparam int RED_LSB   = 5;
  localparam int GREEN_MSB = 4;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_MSB  = 1;
  localparam int BLUE_LSB  = 0;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [POS_W-1:0]   pos_t;

  localparam color_t BOX_COLOR_DEF    = 8'hE0;
  localparam color_t BG_COLOR_DEF     = 8'h03;
  localparam color_t BORDER_COLOR_DEF = 8'hFF;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

endpackage

// File: rtl/vga_box_renderer_if.sv
// Timing-generator-side bundle: raw timing in, colour and re-aligned syncs out.
// master = the side that drives timing, slave = the renderer.
interface vga_box_renderer_if;
  import vga_pkg::*;

  pos_t       hcount;
  pos_t       vcount;
  logic       hs_in;
  logic       vs_in;
  logic       blank_in;
  logic       vblank_in;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       hs_out;
  logic       vs_out;

  modport master (
    output hcount, vcount, hs_in, vs_in, blank_in, vblank_in,
    input  red, green, blue, hs_out, vs_out
  );

  modport slave (
    input  hcount, vcount, hs_in, vs_in, blank_in, vblank_in,
    output red, green, blue, hs_out, vs_out
  );

endinterface

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position plus direction, stepped once per tick.
// The box parks exactly against the wall before turning round.
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int L    = 640,
  parameter int SIZE = 32,
  parameter int STEP = 2
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic tick,
  input  logic en,
  output pos_t pos
);

  localparam logic [POS_W:0] SPAN   = (POS_W+1)'(SIZE + STEP);
  localparam logic [POS_W:0] LIMIT  = (POS_W+1)'(L);
  localparam pos_t           STEP_V = POS_W'(STEP);
  localparam pos_t           PARK   = POS_W'(L - SIZE);

  dir_t            dir;
  dir_t            dir_next;
  pos_t            pos_next;
  logic [POS_W:0]  reach;

  // Far edge after the next step, computed one bit wider so it never wraps
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    reach    = {1'b0, pos} + SPAN;
    if (tick && en) begin
      if (dir == DIR_INC) begin
        if (reach >= LIMIT) begin
          pos_next = PARK;
          dir_next = DIR_DEC;
        end else begin
          pos_next = pos + STEP_V;
        end
      end else begin
        if (pos <= STEP_V) begin
          pos_next = '0;
          dir_next = DIR_INC;
        end else begin
          pos_next = pos - STEP_V;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      dir <= DIR_INC;
    end else begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel-colour stage behind the VGA timing generator: border, bouncing box, background.
// Two-stage pipeline; syncs are delayed alongside so colour and sync leave aligned.
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int     H_RES        = H_RES_DEF,
  parameter int     V_RES        = V_RES_DEF,
  parameter int     BOX_SIZE     = 32,
  parameter int     STEP         = 2,
  parameter color_t BOX_COLOR    = BOX_COLOR_DEF,
  parameter color_t BG_COLOR     = BG_COLOR_DEF,
  parameter color_t BORDER_COLOR = BORDER_COLOR_DEF
) (
  input  logic                pixel_clk,
  input  logic                rst_n,
  vga_box_renderer_if.slave   vga,
  input  logic                move_en,
  output logic [7:0]          frame_count
);

  localparam logic [POS_W:0] BOX_W  = (POS_W+1)'(BOX_SIZE);
  localparam pos_t           H_LAST = POS_W'(H_RES - 1);
  localparam pos_t           V_LAST = POS_W'(V_RES - 1);

  logic   vblank_d;
  logic   frame_tick;
  pos_t   box_x;
  pos_t   box_y;
  logic   in_box;
  logic   on_border;
  logic   in_box_d1;
  logic   on_border_d1;
  logic   hs_d1;
  logic   vs_d1;
  logic   blank_d1;
  logic   hs_d2;
  logic   vs_d2;
  color_t color_next;
  color_t color_d2;

  assign frame_tick = vga.vblank_in & ~vblank_d;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_d    <= 1'b0;
      frame_count <= '0;
    end else begin
      vblank_d <= vga.vblank_in;
      if (frame_tick) frame_count <= frame_count + 8'd1;
    end
  end

  vga_bounce_axis #(.L(H_RES), .SIZE(BOX_SIZE), .STEP(STEP)) u_axis_x (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .tick      (frame_tick),
    .en        (move_en),
    .pos       (box_x)
  );

  vga_bounce_axis #(.L(V_RES), .SIZE(BOX_SIZE), .STEP(STEP)) u_axis_y (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .tick      (frame_tick),
    .en        (move_en),
    .pos       (box_y)
  );

  // Hit tests against the box as it stood before any update on this edge
  always_comb begin
    in_box = ({1'b0, vga.hcount} >= {1'b0, box_x}) &&
             ({1'b0, vga.hcount} <  ({1'b0, box_x} + BOX_W)) &&
             ({1'b0, vga.vcount} >= {1'b0, box_y}) &&
             ({1'b0, vga.vcount} <  ({1'b0, box_y} + BOX_W));
    on_border = (vga.hcount == '0) || (vga.hcount == H_LAST) ||
                (vga.vcount == '0) || (vga.vcount == V_LAST);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_d1    <= 1'b0;
      on_border_d1 <= 1'b0;
      hs_d1        <= 1'b1;
      vs_d1        <= 1'b1;
      blank_d1     <= 1'b1;
    end else begin
      in_box_d1    <= in_box;
      on_border_d1 <= on_border;
      hs_d1        <= vga.hs_in;
      vs_d1        <= vga.vs_in;
      blank_d1     <= vga.blank_in;
    end
  end

  always_comb begin
    color_next = BG_COLOR;
    if (blank_d1)          color_next = '0;
    else if (on_border_d1) color_next = BORDER_COLOR;
    else if (in_box_d1)    color_next = BOX_COLOR;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      color_d2 <= '0;
      hs_d2    <= 1'b1;
      vs_d2    <= 1'b1;
    end else begin
      color_d2 <= color_next;
      hs_d2    <= hs_d1;
      vs_d2    <= vs_d1;
    end
  end

  assign vga.red    = color_d2[RED_MSB:RED_LSB];
  assign vga.green  = color_d2[GREEN_MSB:GREEN_LSB];
  assign vga.blue   = color_d2[BLUE_MSB:BLUE_LSB];
  assign vga.hs_out = hs_d2;
  assign vga.vs_out = vs_d2;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Self-checking bench for vga_box_renderer: hand-written pixel table, a scoreboard
// queue for the 2-cycle pipeline, and a reference box model for the bounce sequences.
module tb_vga_box_renderer;

  localparam int HR = 640;
  localparam int VR = 480;
  localparam int BOX = 32;
  localparam int STP = 2;

  typedef struct {
    logic [7:0] color;
    logic       hs;
    logic       vs;
    int         hc;
    int         vc;
  } exp_t;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        blank;
    logic [7:0]  color;
  } vec_t;

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic       move_en;
  logic [7:0] frame_count;

  vga_box_renderer_if vga();

  vga_box_renderer dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .vga         (vga),
    .move_en     (move_en),
    .frame_count (frame_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[10];

  int m_x, m_y, m_fc;
  bit m_dx, m_dy, m_prev_vb;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_x = 0; m_y = 0; m_fc = 0;
    m_dx = 1'b0; m_dy = 1'b0; m_prev_vb = 1'b0;
  endtask

  task automatic modelAxis(inout int p, inout bit d, input int lim);
    if (!d) begin
      if (p + BOX + STP >= lim) begin p = lim - BOX; d = 1'b1; end
      else p = p + STP;
    end else begin
      if (p <= STP) begin p = 0; d = 1'b0; end
      else p = p - STP;
    end
  endtask

  function automatic logic [7:0] modelColor(input int hc, input int vc, input logic blank);
    if (blank) return 8'h00;
    if (hc == 0 || hc == HR-1 || vc == 0 || vc == VR-1) return 8'hFF;
    if (hc >= m_x && hc < m_x + BOX && vc >= m_y && vc < m_y + BOX) return 8'hE0;
    return 8'h03;
  endfunction

  // Output seen now belongs to the stimulus driven two calls ago
  task automatic checkOutput();
    exp_t e;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check($sformatf("colour(%0d,%0d)", e.hc, e.vc), {vga.red, vga.green, vga.blue}, e.color);
      check($sformatf("hs_out(%0d,%0d)", e.hc, e.vc), vga.hs_out, e.hs);
      check($sformatf("vs_out(%0d,%0d)", e.hc, e.vc), vga.vs_out, e.vs);
    end
  endtask

  task automatic applyStimulus(input int hc, input int vc, input logic hs, input logic vs,
                               input logic blank, input logic vblank,
                               input bit use_exp, input logic [7:0] exp_color);
    exp_t e;
    @(negedge pixel_clk);
    checkOutput();
    vga.hcount    = 11'(hc);
    vga.vcount    = 11'(vc);
    vga.hs_in     = hs;
    vga.vs_in     = vs;
    vga.blank_in  = blank;
    vga.vblank_in = vblank;
    e.color = use_exp ? exp_color : modelColor(hc, vc, blank);
    e.hs = hs; e.vs = vs; e.hc = hc; e.vc = vc;
    sb.push_back(e);
    if (vblank && !m_prev_vb) begin
      m_fc = (m_fc + 1) % 256;
      if (move_en) begin
        modelAxis(m_x, m_dx, HR);
        modelAxis(m_y, m_dy, VR);
      end
    end
    m_prev_vb = vblank;
  endtask

  task automatic tick();
    applyStimulus(0, VR + 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(0, VR + 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkModelBox(input string tag);
    check({tag, ".box_x"}, dut.box_x, m_x);
    check({tag, ".box_y"}, dut.box_y, m_y);
    check({tag, ".frame_count"}, frame_count, m_fc);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, low_cnt, first_low;
    logic hs_v;

    // Box sits at (2,2) after the first frame: columns/rows 2..33 are inside
    vecs[0] = '{11'd2,   11'd2,   1'b0, 8'hE0};
    vecs[1] = '{11'd1,   11'd1,   1'b0, 8'h03};
    vecs[2] = '{11'd0,   11'd5,   1'b0, 8'hFF};
    vecs[3] = '{11'd33,  11'd33,  1'b0, 8'hE0};
    vecs[4] = '{11'd34,  11'd2,   1'b0, 8'h03};
    vecs[5] = '{11'd2,   11'd34,  1'b0, 8'h03};
    vecs[6] = '{11'd639, 11'd100, 1'b0, 8'hFF};
    vecs[7] = '{11'd100, 11'd479, 1'b0, 8'hFF};
    vecs[8] = '{11'd10,  11'd10,  1'b1, 8'h00};
    vecs[9] = '{11'd200, 11'd300, 1'b0, 8'h03};

    rst_n = 1'b0; move_en = 1'b1;
    vga.hcount = '0; vga.vcount = '0; vga.hs_in = 1'b1; vga.vs_in = 1'b1;
    vga.blank_in = 1'b1; vga.vblank_in = 1'b0;
    modelReset();
    #12;
    check("reset.colour", {vga.red, vga.green, vga.blue}, 0);
    check("reset.hs_out", vga.hs_out, 1);
    check("reset.vs_out", vga.vs_out, 1);
    check("reset.frame_count", frame_count, 0);
    @(negedge pixel_clk); rst_n = 1'b1;

    tick();
    check("first.box_x", dut.box_x, 2);
    check("first.box_y", dut.box_y, 2);
    check("first.frame_count", frame_count, 1);

    foreach (vecs[i])
      applyStimulus(vecs[i].hc, vecs[i].vc, 1'b1, 1'b1, vecs[i].blank, 1'b0, 1'b1, vecs[i].color);
    for (int i = 0; i < 40; i++)
      applyStimulus($urandom_range(0, 70), $urandom_range(0, 70), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a line
    repeat (3) applyStimulus(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.colour", {vga.red, vga.green, vga.blue}, 0);
    check("midreset.hs_out", vga.hs_out, 1);
    check("midreset.vs_out", vga.vs_out, 1);
    check("midreset.frame_count", frame_count, 0);
    @(negedge pixel_clk); rst_n = 1'b1;
    sb.delete(); modelReset();
    tick();
    check("postreset.box_x", dut.box_x, 2);
    check("postreset.box_y", dut.box_y, 2);
    check("postreset.frame_count", frame_count, 1);

    move_en = 1'b0;
    repeat (3) tick();
    check("pause.box_x", dut.box_x, 2);
    check("pause.box_y", dut.box_y, 2);
    check("pause.frame_count", frame_count, 4);
    move_en = 1'b1;

    applyStimulus(700, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    low_cnt = 0; first_low = -1;
    for (int i = 0; i < 120; i++) begin
      hs_v = !(i >= 10 && i < 106);
      applyStimulus(656 + i, 10, hs_v, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      if (vga.hs_out == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check("hs_pulse.width", low_cnt, 96);
    check("hs_pulse.start", first_low, 12);

    n = 0;
    while (!(m_x == 606 && m_dx == 1'b0) && n < 800) begin
      tick(); checkModelBox("sweep_right"); n++;
    end
    check("reach606", m_x, 606);
    tick(); check("rightwall.park", dut.box_x, 608);
    tick(); check("rightwall.back", dut.box_x, 606);
    checkModelBox("rightwall");
    n = 0;
    while (!(m_x == 2 && m_dx == 1'b1) && n < 800) begin
      tick(); checkModelBox("sweep_left"); n++;
    end
    check("reach2", m_x, 2);
    tick(); check("leftwall.park", dut.box_x, 0);
    tick(); check("leftwall.back", dut.box_x, 2);
    checkModelBox("leftwall");

    applyStimulus(5, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    @(negedge pixel_clk); rst_n = 1'b1;
    sb.delete(); modelReset();
    repeat (256) tick();
    check("wrap.frame_count", frame_count, 0);
    check("wrap.box_x", dut.box_x, m_x);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_box_renderer.md
Name: vga_box_renderer

Overview:
Pixel-colour stage directly downstream of the VGA timing generator. It consumes hcount/vcount, hs/vs, blank and vblank, and draws three things: a one-pixel screen border, a solid square that moves and bounces, and a flat background. Output is 8-bit RRRGGGBB colour for the Nexys2 DAC pins. hs/vs are re-delayed so that sync and colour leave the block aligned. The box position changes only on the vblank rising edge, so no frame ever shows tearing.

Parameters:
H_RES, 640, visible pixels per line
V_RES, 480, visible lines per frame
BOX_SIZE, 32, box edge length in pixels
STEP, 2, pixels moved per frame per axis; constraint 0 < STEP < BOX_SIZE
BOX_COLOR, 8'hE0, box colour (red)
BG_COLOR, 8'h03, background colour (blue)
BORDER_COLOR, 8'hFF, colour of the screen-edge pixels

Ports:
pixel_clk  in  1  pixel clock, same clock as the timing generator
rst_n  in  1  asynchronous, active-low reset
hcount  in  11  horizontal pixel counter from the timing generator
vcount  in  11  vertical line counter from the timing generator
hs_in  in  1  horizontal sync, active low
vs_in  in  1  vertical sync, active low
blank_in  in  1  1 outside the visible area
vblank_in  in  1  1 during vertical blanking
move_en  in  1  1 = box advances once per frame; 0 = box frozen
red  out  3  colour output
green  out  3  colour output
blue  out  2  colour output
hs_out  out  1  hs_in delayed by 2 cycles
vs_out  out  1  vs_in delayed by 2 cycles
frame_count  out  8  count of vblank rising edges, wraps 255 -> 0

Behaviour:
- Reset (rst_n = 0, takes effect asynchronously):
  - red/green/blue = 0; hs_out = vs_out = 1; frame_count = 0.
  - box_x = box_y = 0; dir_x = dir_y = + (increasing).
  - All pipeline registers cleared: delayed syncs = 1, delayed blank = 1.
- Frame edge detection:
  - vblank_d is a registered copy of vblank_in.
  - frame_tick = vblank_in & ~vblank_d, a single-cycle pulse.
- On frame_tick:
  - frame_count increments unconditionally.
  - If move_en = 1, each axis updates independently using limit L (H_RES for x, V_RES for y):
    - dir = +, and pos + BOX_SIZE + STEP >= L: pos = L - BOX_SIZE, dir becomes -.
    - dir = +, otherwise: pos = pos + STEP.
    - dir = -, and pos <= STEP: pos = 0, dir becomes +.
    - dir = -, otherwise: pos = pos - STEP.
  - If move_en = 0: position and direction are held.
  - frame_tick and a move_en toggle in the same cycle: the sampled move_en value decides.
- Arithmetic: 11-bit unsigned throughout. The compare is done in 12 bits so the sum cannot wrap.
- Stage 1 (registered):
  - in_box = (box_x <= hcount < box_x + BOX_SIZE) && (box_y <= vcount < box_y + BOX_SIZE).
  - on_border = hcount == 0 || hcount == H_RES-1 || vcount == 0 || vcount == V_RES-1.
  - hs, vs and blank are delayed one cycle alongside.
- Stage 2 (registered), colour priority:
  - blank_d1 = 1 gives 0.
  - else on_border gives BORDER_COLOR.
  - else in_box gives BOX_COLOR.
  - else BG_COLOR.
  - Colour split: red = [7:5], green = [4:2], blue = [1:0].
- Latency: exactly 2 pixel_clk cycles from inputs to red/green/blue/hs_out/vs_out.
- Position registers change only on frame_tick, so stage 1 sees a stable box for the whole visible frame.
- Reset mid-frame: outputs go to reset values immediately. After release, the first frame_tick moves the box to (STEP, STEP).

Decomposition:
- Shared package vga_pkg holds:
  - H_RES/V_RES defaults and the colour width (8).
  - Colour field slices (RED_MSB..BLUE_LSB).
  - Default colour constants.
- Natural sub-module: vga_bounce_axis, parameterised by L, SIZE and STEP.
  - Ports: pixel_clk, rst_n, tick, en, pos[10:0].
  - Holds dir internally.
  - Instantiated twice, once for x and once for y.

Test Plan:
1. Reset: rst_n = 0 mid-line -> red/green/blue = 0, hs_out = vs_out = 1, frame_count = 0, all immediately, with no clock edge.
2. First frame: release reset, move_en = 1, first vblank rise -> box at (2,2), frame_count = 1. Pixel (2,2) visible -> BOX_COLOR 2 cycles later; pixel (1,1) -> BG_COLOR; pixel (0,5) -> BORDER_COLOR.
3. Right wall: force box_x = 606 with dir + -> next tick gives box_x = 608, dir -; the following tick gives 606. Left wall: box_x = 2 with dir - -> 0, dir +, then 2.
4. Pause: move_en = 0 across 3 vblank rises -> box_x/box_y unchanged, frame_count advances by 3.
5. Blanking and alignment: hcount = 700 (blank_in = 1) inside box rows -> colour 0. Pulse hs_in low for 96 cycles -> hs_out low for exactly 96 cycles, shifted by 2.
6. Wrap: 256 frame ticks from reset -> frame_count = 0.
